// File: rtl/mac_pkg.sv
// Shared types, widths and arithmetic helpers
// for the 4x4 multiply-accumulate slice.
package mac_pkg;

    localparam int PROD_W = 8;
    localparam int OPND_W = 4;

    typedef struct packed {
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
        logic              last;
        logic              vld;
    } s1_t;

    // Add two zero-extended operands at width w (w <= 32).
    // Result bit 32 flags a carry out of bit w-1; bits [31:0]
    // hold the clamped (sat=1) or wrapped (sat=0) sum.
    function automatic logic [32:0] sat_add(
        input logic [31:0] x,
        input logic [31:0] y,
        input int unsigned w,
        input logic        sat
    );
        logic [32:0] s;
        logic [32:0] mask;
        logic        c;
        s    = {1'b0, x} + {1'b0, y};
        mask = (33'd1 << w) - 33'd1;
        c    = |(s & ~mask);
        if (c) begin
            s = sat ? mask : (s & mask);
        end
        return {c, s[31:0]};
    endfunction

endpackage

// File: rtl/mac_accum_4x4_mul.sv
// Combinational 4x4 unsigned Wallace multiplier:
// two carry-save layers reduce four rows, then one adder.
module mul4x4_comb
    import mac_pkg::*;
(
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic [PROD_W-1:0] p
);

    logic [PROD_W-1:0] r0, r1, r2, r3;
    logic [PROD_W-1:0] s1, c1, s2, c2;

    assign r0 = PROD_W'(a & {OPND_W{b[0]}});
    assign r1 = PROD_W'(a & {OPND_W{b[1]}}) << 1;
    assign r2 = PROD_W'(a & {OPND_W{b[2]}}) << 2;
    assign r3 = PROD_W'(a & {OPND_W{b[3]}}) << 3;

    // First 3:2 layer over rows 0..2
    assign s1 = r0 ^ r1 ^ r2;
    assign c1 = ((r0 & r1) | (r0 & r2) | (r1 & r2)) << 1;

    // Second 3:2 layer folds in row 3
    assign s2 = s1 ^ c1 ^ r3;
    assign c2 = ((s1 & c1) | (s1 & r3) | (c1 & r3)) << 1;

    // The true product fits in 8 bits, so modular carries are safe
    assign p = s2 + c2;

endmodule

// File: rtl/mac_accum_4x4.sv
// Streaming multiply-accumulate: S1 operands, S2 product,
// S3 accumulate; one handshaked sum per last-terminated group.
module mac_accum_4x4
    import mac_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int CNT_W = 8,
    parameter bit SAT   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPND_W-1:0] in_a,
    input  logic [OPND_W-1:0] in_b,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    s1_t               s1;
    logic [PROD_W-1:0] p;
    logic [PROD_W-1:0] s2_p;
    logic              s2_vld;
    logic              s2_last;
    logic              busy;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic              ovf;
    logic              accept;
    logic              done;
    logic [32:0]       add_r;
    logic [ACC_W-1:0]  acc_nx;
    logic [CNT_W-1:0]  cnt_nx;
    logic              ovf_nx;

    assign in_ready = ~busy;
    assign accept   = in_valid & in_ready;
    assign done     = out_valid & out_ready;

    mul4x4_comb u_mul (
        .a (s1.a),
        .b (s1.b),
        .p (p)
    );

    assign add_r  = sat_add(32'(acc), 32'(s2_p), ACC_W, SAT);
    assign acc_nx = add_r[ACC_W-1:0];
    assign ovf_nx = ovf | add_r[32];
    assign cnt_nx = (&cnt) ? cnt : cnt + 1'b1;

    // Operand and product stages advance every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1      <= '0;
            s2_p    <= '0;
            s2_vld  <= 1'b0;
            s2_last <= 1'b0;
        end else begin
            s1.vld <= accept;
            if (accept) begin
                s1.a    <= in_a;
                s1.b    <= in_b;
                s1.last <= in_last;
            end
            s2_vld  <= s1.vld;
            s2_last <= s1.last;
            if (s1.vld) begin
                s2_p <= p;
            end
        end
    end

    // Block new beats from a last beat until its result is taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
        end else if (accept && in_last) begin
            busy <= 1'b1;
        end else if (done) begin
            busy <= 1'b0;
        end
    end

    // Accumulate beats and publish the group result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else if (done) begin
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else if (s2_vld) begin
            acc <= acc_nx;
            cnt <= cnt_nx;
            ovf <= ovf_nx;
            if (s2_last) begin
                out_valid <= 1'b1;
                out_sum   <= acc_nx;
                out_count <= cnt_nx;
                out_ovf   <= ovf_nx;
            end
        end
    end

endmodule

// File: tb/tb_mac_accum_4x4.sv
// Randomised self-checking bench: three instances (16-bit sat,
// 8-bit sat, 8-bit wrap) share stimulus; a sum model checks them.
module tb_mac_accum_4x4;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       in_last;
    logic       out_ready;

    logic        in_ready, out_valid, out_ovf;
    logic [15:0] out_sum;
    logic [7:0]  out_count;

    logic       rdy_s, val_s, ovf_s;
    logic [7:0] sum_s, cnt_s;
    logic       rdy_w, val_w, ovf_w;
    logic [7:0] sum_w, cnt_w;

    int tests;
    int fails;

    int qa[$];
    int qb[$];
    int qg[$];

    mac_accum_4x4 #(.ACC_W(16), .CNT_W(8), .SAT(1'b1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count),
        .out_ovf(out_ovf)
    );

    mac_accum_4x4 #(.ACC_W(8), .CNT_W(8), .SAT(1'b1)) dut_s (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy_s),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(val_s), .out_ready(out_ready),
        .out_sum(sum_s), .out_count(cnt_s),
        .out_ovf(ovf_s)
    );

    mac_accum_4x4 #(.ACC_W(8), .CNT_W(8), .SAT(1'b0)) dut_w (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy_w),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(val_w), .out_ready(out_ready),
        .out_sum(sum_w), .out_count(cnt_w),
        .out_ovf(ovf_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_q();
        qa.delete();
        qb.delete();
        qg.delete();
    endtask

    task automatic push(input int a, input int b, input int g);
        qa.push_back(a);
        qb.push_back(b);
        qg.push_back(g);
    endtask

    // Sends the queued group, waits for its result, checks all
    // three instances, holds backpressure, then takes the result.
    task automatic run_group(input string nm, input bit chk_lat,
                             input int hold);
        int n, tot, lat, e_cnt;
        bit seen, e_ov16, e_ov8;
        int e16, e8s, e8w;
        logic [15:0] held;
        n   = qa.size();
        tot = 0;
        for (int i = 0; i < n; i++) begin
            repeat (qg[i]) begin
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_a     = 4'(qa[i]);
            in_b     = 4'(qb[i]);
            in_last  = (i == n - 1);
            tot      = tot + qa[i] * qb[i];
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
        e_ov16 = (tot >= 65536);
        e16    = e_ov16 ? 65535 : tot;
        e_ov8  = (tot >= 256);
        e8s    = e_ov8 ? 255 : tot;
        e8w    = tot % 256;
        e_cnt  = (n > 255) ? 255 : n;
        seen = 1'b0;
        lat  = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s valid: no out_valid within 20 cycles", nm);
            @(negedge clk);
        end
        if (chk_lat) begin
            tests++;
            if (lat !== 3) begin
                fails++;
                $display("FAIL %s latency: got %0d want 3", nm, lat);
            end
        end
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL %s busy: in_ready=%b want 0", nm, in_ready);
        end
        tests++;
        if (out_sum !== 16'(e16) || out_ovf !== e_ov16 ||
            out_count !== 8'(e_cnt)) begin
            fails++;
            $display("FAIL %s w16: sum=%0d cnt=%0d ovf=%b want %0d %0d %b",
                     nm, out_sum, out_count, out_ovf, e16, e_cnt, e_ov16);
        end
        tests++;
        if (!val_s || sum_s !== 8'(e8s) || ovf_s !== e_ov8 ||
            cnt_s !== 8'(e_cnt)) begin
            fails++;
            $display("FAIL %s w8sat: v=%b sum=%0d cnt=%0d ovf=%b want %0d %0d %b",
                     nm, val_s, sum_s, cnt_s, ovf_s, e8s, e_cnt, e_ov8);
        end
        tests++;
        if (!val_w || sum_w !== 8'(e8w) || ovf_w !== e_ov8 ||
            cnt_w !== 8'(e_cnt)) begin
            fails++;
            $display("FAIL %s w8wrap: v=%b sum=%0d cnt=%0d ovf=%b want %0d %0d %b",
                     nm, val_w, sum_w, cnt_w, ovf_w, e8w, e_cnt, e_ov8);
        end
        held = out_sum;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_a     = 4'($urandom_range(15, 0));
            in_b     = 4'($urandom_range(15, 0));
            in_last  = 1'($urandom_range(1, 0));
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                out_sum !== held) begin
                fails++;
                $display("FAIL %s hold%0d: v=%b rdy=%b sum=%0d want 1 0 %0d",
                         nm, h, out_valid, in_ready, out_sum, held);
            end
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s release: v=%b rdy=%b want 0 1",
                     nm, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0 || out_sum !== 16'd0 ||
            out_count !== 8'd0 || out_ovf !== 1'b0 ||
            in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset: v=%b sum=%0d cnt=%0d ovf=%b rdy=%b want 0 0 0 0 1",
                     out_valid, out_sum, out_count, out_ovf, in_ready);
        end
    endtask

    task automatic test_single();
        clear_q();
        push(15, 15, 0);
        run_group("single", 1'b1, 0);
    endtask

    task automatic test_back_to_back();
        clear_q();
        push(3, 4, 0);
        push(5, 6, 0);
        push(7, 8, 0);
        run_group("b2b", 1'b1, 0);
    endtask

    task automatic test_backpressure();
        clear_q();
        push(9, 10, 0);
        push(11, 12, 0);
        run_group("bp", 1'b0, 5);
        clear_q();
        push(1, 1, 0);
        run_group("bp_next", 1'b1, 0);
    endtask

    task automatic test_saturation();
        clear_q();
        push(15, 15, 0);
        push(15, 15, 0);
        run_group("sat", 1'b0, 0);
    endtask

    task automatic test_bubbles();
        clear_q();
        push(2, 3, 0);
        push(1, 1, 4);
        run_group("bubbles", 1'b0, 0);
    endtask

    task automatic test_reset_mid();
        bit bad;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_a    = 4'(i + 5);
            in_b    = 4'(i + 6);
            in_last = (i == 2);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
                out_sum !== 16'd0)
                bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL rst_mid: v=%b rdy=%b sum=%0d want 0 1 0",
                     out_valid, in_ready, out_sum);
        end
        @(posedge clk);
        #1;
        clear_q();
        push(1, 2, 0);
        run_group("rst_mid_next", 1'b1, 0);
    endtask

    task automatic test_count_sat();
        clear_q();
        for (int i = 0; i < 300; i++) push(15, 15, 0);
        run_group("cnt_sat", 1'b1, 0);
    endtask

    task automatic test_random();
        int n;
        for (int g = 0; g < 25; g++) begin
            clear_q();
            n = $urandom_range(8, 1);
            for (int i = 0; i < n; i++)
                push($urandom_range(15, 0), $urandom_range(15, 0),
                     $urandom_range(2, 0));
            run_group("random", 1'b1, $urandom_range(3, 0));
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_saturation();
        test_bubbles();
        test_reset_mid();
        test_count_sat();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
